// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the MMCM reset sequencer.
package reset_seq_pkg;

  // Sequencer states. The encoding is visible on state_o for debug.
  typedef enum logic [1:0] {
    MMCM_RST  = 2'd0,
    WAIT_LOCK = 2'd1,
    REL_CORE  = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int RELOCK_CNT_W = 8;

  // Add one, but stick at all-ones. The relock counter must never wrap.
  function automatic logic [RELOCK_CNT_W-1:0] sat_inc(input logic [RELOCK_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the MMCM/reset consumers.
// sw_rst_i exists only when RESET_SEQ_SOFTRST_EN is defined.
interface reset_sequencer_if;
  import reset_seq_pkg::*;

  logic                    mmcm_locked_i;
`ifdef RESET_SEQ_SOFTRST_EN
  logic                    sw_rst_i;
`endif
  logic                    mmcm_rst_o;
  logic                    rst_core_o;
  logic                    rst_pwr_o;
  logic                    ready_o;
  logic [RELOCK_CNT_W-1:0] relock_cnt_o;
  logic [1:0]              state_o;

  // Sequencer side.
  modport master (
`ifdef RESET_SEQ_SOFTRST_EN
    input  sw_rst_i,
`endif
    input  mmcm_locked_i,
    output mmcm_rst_o,
    output rst_core_o,
    output rst_pwr_o,
    output ready_o,
    output relock_cnt_o,
    output state_o
  );

  // MMCM / reset-consumer side.
  modport slave (
`ifdef RESET_SEQ_SOFTRST_EN
    output sw_rst_i,
`endif
    output mmcm_locked_i,
    input  mmcm_rst_o,
    input  rst_core_o,
    input  rst_pwr_o,
    input  ready_o,
    input  relock_cnt_o,
    input  state_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer, reset value 0. Used for every
// asynchronous level that crosses into the clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a stable lock,
// releases the core reset and then, later, the power-stage reset. Any loss
// of lock (or a lock timeout) restarts the sequence from the MMCM reset.
// Optional macro RESET_SEQ_SOFTRST_EN adds sw_rst_i, a synchronous software
// reset that behaves like a lock loss and holds the MMCM reset while high.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int CORE_TO_PWR_CYCLES  = 1024,
  parameter int CNT_W               = 17
) (
  input  logic              clk_80MHz_i,
  input  logic              rst_i,
  reset_sequencer_if.master seq_if
);

  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C2P_LAST     = CNT_W'(CORE_TO_PWR_CYCLES - 1);

  logic                    lock_s;
  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        stab_q, stab_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    mmcm_rst_q, rst_core_q, rst_pwr_q, ready_q;
  logic                    bump;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (clk_80MHz_i),
    .rst_i (rst_i),
    .d_i   (seq_if.mmcm_locked_i),
    .q_o   (lock_s)
  );

`ifdef RESET_SEQ_SOFTRST_EN
  logic sw_q;

  // Previous sw_rst_i level, so a held request is counted only once.
  always_ff @(posedge clk_80MHz_i or posedge rst_i) begin
    if (rst_i) sw_q <= 1'b0;
    else       sw_q <= seq_if.sw_rst_i;
  end
`endif

  // Next-state, shared delay counter, stable-lock counter and relock count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    stab_d   = '0;
    relock_d = relock_q;
    bump     = 1'b0;
    case (state_q)
      MMCM_RST: begin
        if (cnt_q == MMCM_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) stab_d = stab_q + 1'b1;
        // Stability is checked first so it wins a tie with the timeout.
        if (lock_s && (stab_q == STABLE_LAST)) begin
          state_d = REL_CORE;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = MMCM_RST;
          cnt_d   = '0;
          stab_d  = '0;
          bump    = 1'b1;
        end
      end
      REL_CORE: begin
        if (!lock_s) begin
          state_d = MMCM_RST;
          cnt_d   = '0;
          bump    = 1'b1;
        end else if (cnt_q == C2P_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Counter parked at zero so it cannot wrap during long runs.
        cnt_d = '0;
        if (!lock_s) begin
          state_d = MMCM_RST;
          bump    = 1'b1;
        end
      end
      default: begin
        state_d = MMCM_RST;
        cnt_d   = '0;
      end
    endcase
`ifdef RESET_SEQ_SOFTRST_EN
    // Software reset overrides everything and pins the MMCM reset phase.
    if (seq_if.sw_rst_i) begin
      state_d = MMCM_RST;
      cnt_d   = '0;
      stab_d  = '0;
      bump    = !sw_q;
    end
`endif
    if (bump) relock_d = sat_inc(relock_q);
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_80MHz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= MMCM_RST;
      cnt_q      <= '0;
      stab_q     <= '0;
      relock_q   <= '0;
      mmcm_rst_q <= 1'b1;
      rst_core_q <= 1'b1;
      rst_pwr_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      relock_q   <= relock_d;
      mmcm_rst_q <= (state_d == MMCM_RST);
      rst_core_q <= (state_d == MMCM_RST) || (state_d == WAIT_LOCK);
      rst_pwr_q  <= (state_d != RUN);
      ready_q    <= (state_d == RUN);
    end
  end

  assign seq_if.mmcm_rst_o   = mmcm_rst_q;
  assign seq_if.rst_core_o   = rst_core_q;
  assign seq_if.rst_pwr_o    = rst_pwr_q;
  assign seq_if.ready_o      = ready_q;
  assign seq_if.relock_cnt_o = relock_q;
  assign seq_if.state_o      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus randomized lock
// waveforms, checked every cycle against a phase/elapsed-time model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int M = 16;   // MMCM reset pulse
  localparam int S = 32;   // stable-lock requirement
  localparam int T = 200;  // lock timeout
  localparam int C = 64;   // core-to-power delay

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  reset_sequencer_if sif();

  reset_sequencer #(
    .MMCM_RST_CYCLES     (M),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .CORE_TO_PWR_CYCLES  (C),
    .CNT_W               (17)
  ) dut (
    .clk_80MHz_i (clk),
    .rst_i       (rst),
    .seq_if      (sif)
  );

  always #5 clk = ~clk;

  // Model: phase (0 mmcm reset, 1 wait lock, 2 core released, 3 run),
  // cycles spent in the phase, current run of synchronized lock highs.
  int m_phase, m_t, m_run, m_relock;
  bit m_d1, m_d2, m_ls, m_sw, m_swprev;

  task automatic m_restart(input bit count);
    if (count) m_relock = (m_relock < 255) ? m_relock + 1 : 255;
    m_phase = 0;
    m_t     = 0;
    m_run   = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_t = 0; m_run = 0; m_relock = 0;
      m_d1 = 0; m_d2 = 0; m_swprev = 0;
    end else begin
      m_ls = m_d2;
      m_d2 = m_d1;
      m_d1 = sif.mmcm_locked_i;
      m_sw = 1'b0;
`ifdef RESET_SEQ_SOFTRST_EN
      m_sw = sif.sw_rst_i;
`endif
      if (m_sw) begin
        m_restart(!m_swprev);
      end else begin
        case (m_phase)
          0: begin
            m_t++;
            if (m_t == M) begin m_phase = 1; m_t = 0; m_run = 0; end
          end
          1: begin
            m_t++;
            m_run = m_ls ? m_run + 1 : 0;
            if (m_run == S) begin m_phase = 2; m_t = 0; m_run = 0; end
            else if (m_t == T) m_restart(1'b1);
          end
          2: begin
            m_t++;
            if (!m_ls) m_restart(1'b1);
            else if (m_t == C) begin m_phase = 3; m_t = 0; end
          end
          default: begin
            if (!m_ls) m_restart(1'b1);
          end
        endcase
      end
      m_swprev = m_sw;
    end
  end

  logic [13:0] act_v, exp_v;

  // Per-cycle comparison against the model, plus the release-order invariant.
  always @(negedge clk) begin
    act_v = {sif.mmcm_rst_o, sif.rst_core_o, sif.rst_pwr_o, sif.ready_o,
             sif.relock_cnt_o, sif.state_o};
    exp_v = {m_phase == 0, m_phase <= 1, m_phase != 3, m_phase == 3,
             8'(m_relock), 2'(m_phase)};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_compare t=%0t {mmcm,core,pwr,ready,relock,state} actual=%b expected=%b",
               $time, act_v, exp_v);
    end
    tests++;
    assert (!(sif.rst_pwr_o === 1'b0 && sif.rst_core_o !== 1'b0)) else begin
      fails++;
      $display("FAIL order_invariant t=%0t rst_pwr_o=%b rst_core_o=%b required rst_core_o=0",
               $time, sif.rst_pwr_o, sif.rst_core_o);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Assert rst_i away from clock edges; release two cycles later so the
  // next rising edge is edge 1 of the new sequence.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int f_mmcm, f_core, f_pwr, f_ready, w;
    sif.mmcm_locked_i = 1'b0;
`ifdef RESET_SEQ_SOFTRST_EN
    sif.sw_rst_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_mmcm_rst", sif.mmcm_rst_o, 1);
    check("reset_rst_core", sif.rst_core_o, 1);
    check("reset_rst_pwr", sif.rst_pwr_o, 1);
    check("reset_ready", sif.ready_o, 0);
    check("reset_relock", sif.relock_cnt_o, 0);
    check("reset_state", sif.state_o, 0);

    // Power-up, then lock loss in RUN and recovery.
    do_reset();
    f_mmcm = -1; f_core = -1; f_pwr = -1; f_ready = -1;
    for (int i = 1; i <= 420; i++) begin
      @(negedge clk);
      if (f_mmcm  < 0 && !sif.mmcm_rst_o) f_mmcm  = i;
      if (f_core  < 0 && !sif.rst_core_o) f_core  = i;
      if (f_pwr   < 0 && !sif.rst_pwr_o)  f_pwr   = i;
      if (f_ready < 0 &&  sif.ready_o)    f_ready = i;
      if (i == 100) sif.mmcm_locked_i = 1'b1;
      if (i == 250) check("pwrup_relock", sif.relock_cnt_o, 0);
      if (i == 300) sif.mmcm_locked_i = 1'b0;
      if (i == 302) check("loss_still_ready", sif.ready_o, 1);
      if (i == 303) begin
        check("loss_core", sif.rst_core_o, 1);
        check("loss_pwr", sif.rst_pwr_o, 1);
        check("loss_ready", sif.ready_o, 0);
        check("loss_mmcm", sif.mmcm_rst_o, 1);
        check("loss_relock", sif.relock_cnt_o, 1);
      end
      if (i == 310) sif.mmcm_locked_i = 1'b1;
      if (i == 420) check("relock_ready", sif.ready_o, 1);
    end
    check("pwrup_mmcm_fall", f_mmcm, M);
    check("pwrup_core_fall", f_core, 100 + 2 + S);
    check("pwrup_pwr_fall", f_pwr, 100 + 2 + S + C);
    check("pwrup_ready_rise", f_ready, 100 + 2 + S + C);

    // Glitchy lock: one low cycle restarts the stability window.
    sif.mmcm_locked_i = 1'b0;
    do_reset();
    f_core = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (f_core < 0 && !sif.rst_core_o) f_core = i;
      if (i == 100) sif.mmcm_locked_i = 1'b1;
      if (i == 120) sif.mmcm_locked_i = 1'b0;
      if (i == 121) sif.mmcm_locked_i = 1'b1;
    end
    check("glitch_core_fall", f_core, 121 + 2 + S);

    // Timeout: lock never comes, MMCM reset re-pulses every M+T cycles.
    sif.mmcm_locked_i = 1'b0;
    do_reset();
    for (int i = 1; i <= 3 * (M + T); i++) begin
      @(negedge clk);
      if (i == M + T - 1) begin
        check("tmo_before_mmcm", sif.mmcm_rst_o, 0);
        check("tmo_before_relock", sif.relock_cnt_o, 0);
      end
      if (i == M + T) begin
        check("tmo_mmcm", sif.mmcm_rst_o, 1);
        check("tmo_relock", sif.relock_cnt_o, 1);
      end
      if (i == M + T + M - 1) check("tmo_pulse_held", sif.mmcm_rst_o, 1);
      if (i == M + T + M)     check("tmo_pulse_end", sif.mmcm_rst_o, 0);
    end
    check("tmo_relock_3", sif.relock_cnt_o, 3);

`ifdef RESET_SEQ_SOFTRST_EN
    // Soft reset: 5-cycle pulse from RUN.
    sif.mmcm_locked_i = 1'b1;
    do_reset();
    repeat (150) @(negedge clk);
    check("sw_in_run", sif.ready_o, 1);
    sif.sw_rst_i = 1'b1;
    for (int i = 1; i <= M + 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("sw_core", sif.rst_core_o, 1);
        check("sw_ready", sif.ready_o, 0);
      end
      if (i == 5) sif.sw_rst_i = 1'b0;
      if (i == M + 4) check("sw_mmcm_held", sif.mmcm_rst_o, 1);
      if (i == M + 5) begin
        check("sw_mmcm_fall", sif.mmcm_rst_o, 0);
        check("sw_relock", sif.relock_cnt_o, 1);
      end
    end
`endif

    // Randomized lock waveform with occasional asynchronous resets.
    sif.mmcm_locked_i = 1'b0;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      len = $urandom_range(1, 200);
      sif.mmcm_locked_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 599) == 0) begin
          #3 rst = 1'b1;
          #4 rst = 1'b0;
        end
`ifdef RESET_SEQ_SOFTRST_EN
        sif.sw_rst_i = ($urandom_range(0, 149) == 0);
`endif
      end
    end
`ifdef RESET_SEQ_SOFTRST_EN
    sif.sw_rst_i = 1'b0;
`endif

    // Saturation: 300 lock losses, each after the core has been released.
    sif.mmcm_locked_i = 1'b0;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      sif.mmcm_locked_i = 1'b1;
      w = 0;
      while (sif.rst_core_o && w < 400) begin
        @(negedge clk);
        w++;
      end
      check("sat_core_release_in_time", int'(w < 400), 1);
      sif.mmcm_locked_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("sat_relock_dut", sif.relock_cnt_o, 255);
    check("sat_relock_model", m_relock, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the MMCM clock-generation stage.
- Drives the MMCM RST input and watches its LOCKED output.
- Once the generated clocks are stable, releases the core-logic reset first and the power-stage (gate-drive) reset last, so the bridge drivers never toggle while clocks are invalid.
- Any loss of lock forces everything back into reset and restarts the sequence.

Parameters:
- MMCM_RST_CYCLES, 16, cycles mmcm_rst_o is held high per attempt (min 1).
- LOCK_STABLE_CYCLES, 256, consecutive synchronized-locked cycles required before releasing core reset.
- LOCK_TIMEOUT_CYCLES, 65535, cycles allowed in WAIT_LOCK before retrying the MMCM reset.
- CORE_TO_PWR_CYCLES, 1024, cycles between core reset release and power reset release.
- CNT_W, 17, width of the shared delay counter; must hold the largest of the above.

Ports:
- clk_80MHz_i  in  1  system clock (buffered 80 MHz MMCM output)
- rst_i  in  1  asynchronous, active-high reset
- mmcm_locked_i  in  1  MMCM LOCKED; asynchronous to clk_80MHz_i
- mmcm_rst_o  out  1  to MMCM RST
- rst_core_o  out  1  active-high reset for core logic
- rst_pwr_o  out  1  active-high reset for the gate-drive / power stage
- ready_o  out  1  high only in RUN
- relock_cnt_o  out  8  saturating count of lock losses and timeouts
- state_o  out  2  current state encoding, for debug

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-high.
  - Clock port is clk_80MHz_i; reset port is rst_i.
- Reset values (while rst_i high):
  - State = MMCM_RST, counter = 0.
  - mmcm_rst_o = 1, rst_core_o = 1, rst_pwr_o = 1, ready_o = 0.
  - relock_cnt_o = 0.
- Lock input:
  - mmcm_locked_i passes through a 2-flop synchronizer, producing lock_s.
  - Lock-edge latency is 2 cycles.
- All outputs are registered. No combinational path from input to output.
- State encoding: MMCM_RST = 0, WAIT_LOCK = 1, REL_CORE = 2, RUN = 3.
- MMCM_RST:
  - mmcm_rst_o = 1, core and pwr resets high.
  - The counter counts to MMCM_RST_CYCLES-1, then clears and moves to WAIT_LOCK.
- WAIT_LOCK:
  - mmcm_rst_o = 0. The counter increments every cycle.
  - A separate stable counter increments while lock_s = 1 and clears to 0 on any lock_s = 0 cycle.
  - Stable counter reaches LOCK_STABLE_CYCLES → go to REL_CORE; the counter clears.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 without stability → go to MMCM_RST; relock_cnt increments.
  - If both conditions hit in the same cycle, stability wins.
- REL_CORE:
  - rst_core_o = 0; rst_pwr_o stays 1.
  - After CORE_TO_PWR_CYCLES cycles → go to RUN.
- RUN:
  - rst_pwr_o = 0, ready_o = 1. The block stays here indefinitely.
- Lock loss:
  - Trigger: lock_s = 0 in REL_CORE or RUN.
  - Next clock edge: rst_core_o = 1, rst_pwr_o = 1, ready_o = 0; state → MMCM_RST, counter clears, relock_cnt increments.
  - The reset assertion is registered: one cycle after lock_s falls.
- relock_cnt saturates at 255 and never wraps.
- Output ordering invariant: rst_pwr_o = 0 implies rst_core_o = 0 in every cycle.
- Reset mid-sequence: rst_i asserted in any state returns all outputs to their reset values immediately (asynchronous assert). Release is synchronous to the next clock edge.

Optional Feature:
- Macro: RESET_SEQ_SOFTRST_EN.
- When defined:
  - Adds input sw_rst_i (1 bit, synchronous to clk_80MHz_i).
  - A high level in any state causes the same transition as a lock loss, including the relock_cnt increment.
  - While sw_rst_i stays high, the FSM holds in MMCM_RST with the counter held at 0.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Shared package reset_seq_pkg holds:
  - the 2-bit state typedef with the named encodings above;
  - the RELOCK_CNT_W = 8 constant.
- Sub-module sync_2ff: generic 2-flop bit synchronizer with reset value 0. Reused by other CDC points in the design.
- Counters and FSM stay in the top module.

Test Plan:
- Power-up: release rst_i; mmcm_locked_i rises 100 cycles later and stays high → mmcm_rst_o falls at cycle 16. rst_core_o falls 2 + 256 cycles after lock rises (±1 for registering). rst_pwr_o and ready_o follow 1024 cycles later. relock_cnt_o = 0.
- Glitchy lock: lock high 200 cycles, low 1 cycle, then high → stable counter restarts; core release occurs 256 cycles after the final rise, not the first.
- Timeout: keep lock low, with LOCK_TIMEOUT_CYCLES set to 1000 for this test → mmcm_rst_o re-pulses for 16 cycles every 1016 cycles; relock_cnt_o increments by 1 per retry.
- Lock loss in RUN: drop mmcm_locked_i → within 3 cycles rst_core_o = rst_pwr_o = 1, ready_o = 0, mmcm_rst_o = 1. relock_cnt_o increments by 1. Full sequence repeats when lock returns.
- Saturation: force 300 lock losses → relock_cnt_o holds at 255.
- Soft reset (RESET_SEQ_SOFTRST_EN defined): 5-cycle sw_rst_i pulse in RUN → resets assert next cycle; mmcm_rst_o is held through the pulse plus 16 cycles; sequence restarts.
- All scenarios: an assertion checks the invariant rst_pwr_o = 0 implies rst_core_o = 0, every cycle.
